// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback path.
// Holds default data/index widths, register count helper and select encoding.
package rf_pkg;

    localparam int RF_XLEN    = 32;
    localparam int RF_RFIDX   = 5;
    localparam int RF_AGE_MAX = 4;

    // Number of architectural registers addressed by an index of idx_w bits.
    function automatic int rf_nreg(input int idx_w);
        return 1 << idx_w;
    endfunction

    localparam int RF_NREG = rf_nreg(RF_RFIDX);

    // Source driving the write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LNG  = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO buffering long-latency results ahead of the write port.
// Ports: i_clk/i_rst, i_push/i_din, i_pop, o_full, o_empty, o_head.
module wb_fifo #(
    parameter int W = 37
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push;
    logic         do_pop;

    assign o_full  = (cnt_q == 2'd2);
    assign o_empty = (cnt_q == 2'd0);
    assign o_head  = rd_q ? mem1_q : mem0_q;

    // Guarded here too so a misbehaving caller cannot corrupt the count.
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (do_push) begin
            if (wr_q) begin
                mem1_d = i_din;
            end else begin
                mem0_d = i_din;
            end
            wr_d = ~wr_q;
        end
        if (do_pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: ALU results win, long results queue in a
// 2-entry FIFO, a busy scoreboard tracks pending long writes for hazards.
// Ports: i_clk/i_rst; issue i_iss_*/o_iss_rdy/o_iss_hold; ALU result
// i_alu_*; long result i_lng_*/o_lng_rdy; write port o_rdwen/o_rdidx/
// o_rd_wdata; hazard query i_rs1idx/i_rs2idx -> o_rs1_busy/o_rs2_busy.
module rf_writeback
    import rf_pkg::*;
#(
    parameter int XLEN    = RF_XLEN,
    parameter int RFIDX   = RF_RFIDX,
    parameter int AGE_MAX = RF_AGE_MAX
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_iss_vld,
    input  logic [RFIDX-1:0] i_iss_rdidx,
    output logic             o_iss_rdy,
    output logic             o_iss_hold,
    input  logic             i_alu_vld,
    input  logic [RFIDX-1:0] i_alu_rdidx,
    input  logic [XLEN-1:0]  i_alu_wdata,
    input  logic             i_lng_vld,
    input  logic [RFIDX-1:0] i_lng_rdidx,
    input  logic [XLEN-1:0]  i_lng_wdata,
    output logic             o_lng_rdy,
    output logic             o_rdwen,
    output logic [RFIDX-1:0] o_rdidx,
    output logic [XLEN-1:0]  o_rd_wdata,
    input  logic [RFIDX-1:0] i_rs1idx,
    input  logic [RFIDX-1:0] i_rs2idx,
    output logic             o_rs1_busy,
    output logic             o_rs2_busy
);

    localparam int NREG = rf_nreg(RFIDX);
    localparam int AW   = $clog2(AGE_MAX + 1);
    localparam int EW   = RFIDX + XLEN;

    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_head;
    logic [RFIDX-1:0] head_idx;
    logic [XLEN-1:0]  head_data;
    logic             push;
    logic             pop;
    wb_sel_e          sel;

    logic [NREG-1:0]  busy_q, busy_d;
    logic [AW-1:0]    age_q, age_d;
    logic             rdwen_q, rdwen_d;
    logic [RFIDX-1:0] rdidx_q, rdidx_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;

    assign {head_idx, head_data} = fifo_head;

    // Readiness comes from the registered fill level, so a pop in the
    // same cycle never makes room for a push.
    assign o_lng_rdy = !fifo_full;
    assign push      = i_lng_vld && !fifo_full;

    assign o_iss_rdy  = !busy_q[i_iss_rdidx] || (i_iss_rdidx == '0);
    assign o_rs1_busy = busy_q[i_rs1idx] && (i_rs1idx != '0);
    assign o_rs2_busy = busy_q[i_rs2idx] && (i_rs2idx != '0);
    assign o_iss_hold = (age_q >= AW'(AGE_MAX));

    wb_fifo #(
        .W (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_din   ({i_lng_rdidx, i_lng_wdata}),
        .i_pop   (pop),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_head  (fifo_head)
    );

    always_comb begin
        sel     = SEL_NONE;
        rdwen_d = 1'b0;
        rdidx_d = '0;
        wdata_d = '0;
        busy_d  = busy_q;
        age_d   = age_q;

        if (i_alu_vld) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel = SEL_LNG;
        end
        pop = (sel == SEL_LNG);

        unique case (sel)
            SEL_ALU: begin
                rdidx_d = i_alu_rdidx;
                wdata_d = i_alu_wdata;
            end
            SEL_LNG: begin
                rdidx_d = head_idx;
                wdata_d = head_data;
            end
            default: ;
        endcase
        // x0 writes are dropped but still consume the FIFO entry.
        rdwen_d = (sel != SEL_NONE) && (rdidx_d != '0);

        // Age tracks how long the head has been starved by ALU traffic.
        if (pop) begin
            age_d = '0;
        end else if (!fifo_empty && i_alu_vld && !o_iss_hold) begin
            age_d = age_q + AW'(1);
        end

        // Clear first so a same-cycle set on the same index wins.
        if (pop) begin
            busy_d[head_idx] = 1'b0;
        end
        if (i_iss_vld && o_iss_rdy && (i_iss_rdidx != '0)) begin
            busy_d[i_iss_rdidx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q  <= '0;
            age_q   <= '0;
            rdwen_q <= 1'b0;
            rdidx_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            age_q   <= age_d;
            rdwen_q <= rdwen_d;
            rdidx_q <= rdidx_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_rdwen    = rdwen_q;
    assign o_rdidx    = rdidx_q;
    assign o_rd_wdata = wdata_q;

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 SHALL have parameter RFIDX, default 5, meaning register index width (32 registers).
REQ-003 SHALL have parameter AGE_MAX, default 4, meaning long-result wait cycles before issue hold.
REQ-004 SHALL have port i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_iss_vld  in  1  long-latency op issued this cycle.
REQ-007 SHALL have port i_iss_rdidx  in  RFIDX  destination of issued long op.
REQ-008 SHALL have port o_iss_rdy  out  1  long op with i_iss_rdidx may issue (no WAW).
REQ-009 SHALL have port o_iss_hold  out  1  request to stall issue (starvation guard).
REQ-010 SHALL have port i_alu_vld / i_alu_rdidx / i_alu_wdata  in  1/RFIDX/XLEN  single-cycle result, always accepted.
REQ-011 SHALL have port i_lng_vld / i_lng_rdidx / i_lng_wdata  in  1/RFIDX/XLEN  long-latency result.
REQ-012 SHALL have port o_lng_rdy  out  1  long result accepted when i_lng_vld & o_lng_rdy.
REQ-013 SHALL have port o_rdwen / o_rdidx / o_rd_wdata  out  1/RFIDX/XLEN  register-file write port.
REQ-014 SHALL have port i_rs1idx, i_rs2idx  in  RFIDX  hazard query indices.
REQ-015 SHALL have port o_rs1_busy, o_rs2_busy  out  1  queried register has a pending long write.

Function
REQ-016 SHALL buffer long results in a 2-entry FIFO; o_lng_rdy = FIFO not full at cycle start (no push when full, even with simultaneous pop).
REQ-017 SHALL each cycle select: ALU result if i_alu_vld, else FIFO head if non-empty, else none.
REQ-018 SHALL register the selected result to o_rdwen/o_rdidx/o_rd_wdata with 1-cycle latency; o_rdwen=0 when none selected.
REQ-019 SHALL suppress o_rdwen for rdidx 0 while still popping the FIFO entry.
REQ-020 SHALL keep 32-bit busy scoreboard: set bit on i_iss_vld & o_iss_rdy & rdidx!=0; clear bit on the edge a FIFO entry is popped to the write port.
REQ-021 SHALL give set priority over clear when both target the same index in one cycle.
REQ-022 SHALL drive o_iss_rdy = !busy[i_iss_rdidx] | (i_iss_rdidx==0), combinational.
REQ-023 SHALL drive o_rsN_busy = busy[i_rsNidx] & (i_rsNidx!=0), combinational.
REQ-024 SHALL count cycles the FIFO head is blocked by ALU; assert o_iss_hold while count >= AGE_MAX; reset count on pop.
REQ-025 SHALL leave FIFO contents unchanged on a push into an empty FIFO coinciding with ALU selection (no same-cycle passthrough).

Reset
REQ-026 SHALL on i_rst clear FIFO (empty), busy scoreboard, age counter, o_rdwen=0, o_rdidx=0, o_rd_wdata=0, o_iss_hold=0; o_lng_rdy=1 first cycle after reset.
REQ-027 SHALL discard in-flight FIFO entries on reset mid-operation without emitting writes.

Structure
REQ-028 SHALL take XLEN, RFIDX, register count from shared package rf_pkg.
REQ-029 SHALL implement the 2-entry buffer as sub-module wb_fifo (push/pop/full/empty/head).

Verification
REQ-030 ALU only: i_alu_vld, rdidx 5, wdata 0x1234 -> next cycle o_rdwen=1, o_rdidx=5, o_rd_wdata=0x1234.
REQ-031 Scoreboard: issue rd 7 -> o_rs1_busy=1 for rs1idx 7, o_iss_rdy=0 for rd 7; long result rd 7 0xAA pops -> write seen, busy cleared same edge.
REQ-032 Backpressure: three long results back-to-back with ALU valid every cycle -> o_lng_rdy=0 after two accepts; o_iss_hold=1 after 4 blocked cycles; drops ALU -> FIFO drains in order.
REQ-033 x0: ALU and long results to rdidx 0 -> o_rdwen stays 0, FIFO still pops, busy never set for 0.
REQ-034 Reset mid-op: FIFO holding 2 entries, busy bits 3,9 set, assert i_rst -> no writes, all busy 0, o_lng_rdy=1 after release.
